// File: rtl/onehot_pkg.sv
// onehot_pkg: shared constants for the taxel mux control bus.
// Holds the special configuration codes and their switch patterns, the
// decoder FSM state encoding, and the classification record type.
package onehot_pkg;

    localparam int          N_LINES         = 26;
    localparam int          NUM_HEM         = 24;
    localparam logic [4:0]  CODE_TEST_LOCAL = 5'd30;
    localparam logic [4:0]  CODE_TEST_ONLY  = 5'd31;
    localparam logic [25:0] PAT_TEST_LOCAL  = 26'h2000001;
    localparam logic [25:0] PAT_TEST_ONLY   = 26'h2000000;

    localparam logic [1:0]  ST_SETTLE = 2'd0;
    localparam logic [1:0]  ST_EMIT   = 2'd1;
    localparam logic [1:0]  ST_HOLD   = 2'd2;

    typedef struct packed {
        logic [4:0] code;
        logic       idle;
        logic       illegal;
    } cls_t;

    localparam cls_t CLS_IDLE = '{code: 5'd0, idle: 1'b1, illegal: 1'b0};

endpackage

// File: rtl/onehot_dec_p_classify.sv
// onehot_classify: combinational classifier of an active-high switch pattern.
// Ports:
//   p       in  26  active-high switch pattern (bit i set = switch i closed)
//   code    out 5   configuration code (0 when idle or illegal)
//   idle    out 1   no switch closed
//   illegal out 1   pattern is not a legal encoding
module onehot_classify
    import onehot_pkg::*;
(
    input  logic [25:0] p,
    output logic [4:0]  code,
    output logic        idle,
    output logic        illegal
);

    logic [4:0] ones;
    logic [4:0] idx;

    always_comb begin
        ones = 5'd0;
        idx  = 5'd0;
        for (int i = 0; i < N_LINES; i++) begin
            if (p[i]) begin
                ones = ones + 5'd1;
                idx  = 5'(i);
            end
        end
    end

    always_comb begin
        code    = 5'd0;
        idle    = 1'b0;
        illegal = 1'b0;
        if (p == 26'd0) begin
            idle = 1'b1;
        end else if (p == PAT_TEST_LOCAL) begin
            code = CODE_TEST_LOCAL;
        end else if (p == PAT_TEST_ONLY) begin
            code = CODE_TEST_ONLY;
        end else if (ones == 5'd1 && idx <= 5'(NUM_HEM)) begin
            code = idx;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/onehot_dec_p.sv
// onehot_dec_p: readback decoder / monitor for the taxel mux control bus.
// Samples the active-low control lines, waits for STABLE_CYC identical
// samples, and reports each new stable classification over valid/ready.
// Ports:
//   clk, rst      clock, async active-high reset
//   n_mux_ctrl    in  26    active-low switch controls
//   out_ready     in  1     consumer accepts held event
//   err_clr       in  1     clears overrun and err_cnt
//   out_valid     out 1     event held on out_code/out_idle/out_illegal
//   out_code      out 5     decoded configuration code
//   out_idle      out 1     no switch closed
//   out_illegal   out 1     illegal pattern
//   overrun       out 1     sticky: held event was overwritten
//   err_cnt       out ERR_W saturating count of emitted illegal events
module onehot_dec_p
    import onehot_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [25:0]      n_mux_ctrl,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [4:0]       out_code,
    output logic             out_idle,
    output logic             out_illegal,
    output logic             overrun,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

    logic [25:0] s_q;
    logic [25:0] smp;
    logic        chg;
    logic [7:0]  cnt;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        emit;
    cls_t        cls;
    cls_t        last_rep;

    assign smp  = ~n_mux_ctrl;
    // chg is true when the edge about to happen loads a different pattern.
    assign chg  = (smp != s_q);
    assign emit = (state_q == ST_EMIT);

    onehot_classify u_cls (
        .p       (s_q),
        .code    (cls.code),
        .idle    (cls.idle),
        .illegal (cls.illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETTLE: if (!chg && cnt == STABLE_LIM)
                           state_d = (cls != last_rep) ? ST_EMIT : ST_HOLD;
            ST_EMIT:   state_d = chg ? ST_SETTLE : ST_HOLD;
            ST_HOLD:   if (chg) state_d = ST_SETTLE;
            default:   state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 26'd0;
            cnt     <= 8'd0;
            state_q <= ST_SETTLE;
        end else begin
            s_q     <= smp;
            state_q <= state_d;
            if (chg)
                cnt <= 8'd1;
            else if (cnt < STABLE_LIM)
                cnt <= cnt + 8'd1;
        end
    end

    // Output register: an EMIT always replaces the held event (latest wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_code    <= 5'd0;
            out_idle    <= 1'b0;
            out_illegal <= 1'b0;
            last_rep    <= CLS_IDLE;
        end else if (emit) begin
            out_valid   <= 1'b1;
            out_code    <= cls.code;
            out_idle    <= cls.idle;
            out_illegal <= cls.illegal;
            last_rep    <= cls;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Error logic: clear has priority over a same-cycle set/increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            overrun <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (emit && out_valid && !out_ready)
                overrun <= 1'b1;
            if (emit && cls.illegal && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_dec_p.sv
// Bench for onehot_dec_p: sample-history reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_onehot_dec_p;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] n_mux_ctrl;
    logic        out_ready;
    logic        err_clr;

    logic        o_valid, o_idle, o_ill, o_ovr;
    logic [4:0]  o_code;
    logic [7:0]  o_err;
    logic        d1_valid, d1_idle, d1_ill, d1_ovr;
    logic [4:0]  d1_code;
    logic [1:0]  d1_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_dec_p #(.STABLE_CYC(S), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .n_mux_ctrl(n_mux_ctrl), .out_ready(out_ready),
        .err_clr(err_clr), .out_valid(o_valid), .out_code(o_code),
        .out_idle(o_idle), .out_illegal(o_ill), .overrun(o_ovr), .err_cnt(o_err)
    );

    // Fast-settling, narrow-counter variant for latency and saturation checks.
    onehot_dec_p #(.STABLE_CYC(1), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .n_mux_ctrl(n_mux_ctrl), .out_ready(out_ready),
        .err_clr(err_clr), .out_valid(d1_valid), .out_code(d1_code),
        .out_idle(d1_idle), .out_illegal(d1_ill), .overrun(d1_ovr), .err_cnt(d1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference classification straight from the pattern rules.
    function automatic logic [6:0] classify(input logic [25:0] x);
        if (x == 26'd0)                              return {5'd0, 1'b1, 1'b0};
        if (x == 26'h2000001)                        return {5'd30, 1'b0, 1'b0};
        if (x == 26'h2000000)                        return {5'd31, 1'b0, 1'b0};
        if ($countones(x) == 1 && !x[25])            return {5'($clog2(x)), 1'b0, 1'b0};
        return {5'd0, 1'b0, 1'b1};
    endfunction

    function automatic logic [25:0] enc(input int code);
        logic [25:0] one;
        one = 26'd1;
        if (code == 30) return 26'h2000001;
        if (code == 31) return 26'h2000000;
        return one << code;
    endfunction

    // Model: a pattern seen in S+1 consecutive samples is judged once;
    // if its classification differs from the last report, it is presented
    // on the following edge.
    logic [25:0] m_prev;
    int          m_run;
    logic [6:0]  m_last, m_pev;
    logic        m_pend;
    logic        m_valid, m_ovr;
    logic [6:0]  m_out;
    logic [7:0]  m_err;

    always @(posedge clk or posedge rst) begin
        logic [25:0] x;
        logic [6:0]  c;
        if (rst) begin
            m_prev = 26'd0; m_run = 0; m_last = {5'd0, 1'b1, 1'b0};
            m_pend = 1'b0; m_pev = 7'd0; m_valid = 1'b0; m_out = 7'd0;
            m_ovr = 1'b0; m_err = 8'd0;
        end else begin
            if (m_pend) begin
                if (m_valid && !out_ready) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_out   = m_pev;
                if (m_pev[0] && m_err != 8'hFF) m_err = m_err + 8'd1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (err_clr) begin
                m_ovr = 1'b0;
                m_err = 8'd0;
            end
            x = ~n_mux_ctrl;
            m_run = (x == m_prev) ? m_run + 1 : 1;
            m_prev = x;
            m_pend = 1'b0;
            if (m_run == S + 1) begin
                c = classify(x);
                if (c != m_last) begin
                    m_pend = 1'b1;
                    m_pev  = c;
                    m_last = c;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model", {o_valid, o_code, o_idle, o_ill, o_ovr, o_err},
                     {m_valid, m_out, m_ovr, m_err});
    end

    // Event monitor for the directed scenarios.
    int         ev_cnt = 0;
    int         ill_cnt = 0;
    logic [6:0] ev_q[$];

    always @(negedge clk) begin
        if (!rst && o_valid && out_ready) begin
            ev_cnt++;
            ev_q.push_back({o_code, o_idle, o_ill});
            if (o_ill) ill_cnt++;
        end
    end

    task automatic hold(input logic [25:0] pat, input int n);
        n_mux_ctrl = ~pat;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        int sweep[27];
        rst = 1'b1; n_mux_ctrl = 26'h3FFFFFF; out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {o_valid, o_code, o_idle, o_ill, o_ovr, o_err}, 32'd0);
        chk("reset_outs1", {d1_valid, d1_code, d1_idle, d1_ill, d1_ovr, d1_err}, 32'd0);
        rst = 1'b0;

        // All switches open after reset: nothing reported.
        repeat (20) @(negedge clk);
        chk("idle_no_event", ev_cnt, 0);
        chk("idle_err", o_err, 0);

        // Code 9 latency: valid at edge k+5 (k+2 for STABLE_CYC=1).
        n_mux_ctrl = ~26'h0000200;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            chk($sformatf("lat_valid_%0d", j), o_valid, (j == 6));
            chk($sformatf("lat1_valid_%0d", j), d1_valid, (j == 3));
            if (j == 6) chk("lat_code9", {o_code, o_idle, o_ill}, {5'd9, 1'b0, 1'b0});
        end
        chk("lat_one_event", ev_cnt, 1);

        // Sweep every legal code.
        for (int i = 0; i < 25; i++) sweep[i] = i;
        sweep[25] = 30; sweep[26] = 31;
        ev_q.delete();
        base = ev_cnt;
        for (int i = 0; i < 27; i++) hold(enc(sweep[i]), 8);
        chk("sweep_count", ev_cnt - base, 27);
        for (int i = 0; i < 27 && i < ev_q.size(); i++)
            chk($sformatf("sweep_ev_%0d", sweep[i]), ev_q[i], {5'(sweep[i]), 1'b0, 1'b0});

        // Illegal patterns, separated by a legal code so each is a new report.
        hold(26'h2000002, 8); hold(enc(1), 8); hold(26'h0000003, 8);
        chk("ill_err2", o_err, 2);
        hold(enc(1), 8); hold(26'h2000002, 8); hold(enc(1), 8); hold(26'h0000003, 8);
        chk("ill_err4", o_err, 4);
        chk("ill_events", ill_cnt, 4);
        chk("ill_sat1", d1_err, 3);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", o_err, 0);
        chk("err_clr1", d1_err, 0);

        // Short glitch to code 5 inside code 7.
        base = ev_cnt;
        ev_q.delete();
        hold(enc(7), 8); hold(enc(5), 3); hold(enc(7), 8);
        chk("glitch_count", ev_cnt - base, 1);
        if (ev_q.size() > 0) chk("glitch_code", ev_q[0], {5'd7, 1'b0, 1'b0});

        // Overwrite while the consumer stalls.
        out_ready = 1'b0;
        hold(enc(3), 8); hold(enc(4), 8);
        chk("ovr_valid", o_valid, 1);
        chk("ovr_code", o_code, 4);
        chk("ovr_flag", o_ovr, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ovr_drain", o_valid, 0);

        // Reset mid-settle aborts the pending event.
        hold(enc(6), 2);
        #2 rst = 1'b1;
        #1 chk("midrst_outs", {o_valid, o_code, o_idle, o_ill, o_ovr, o_err}, 32'd0);
        n_mux_ctrl = 26'h3FFFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = ev_cnt;
        repeat (12) @(negedge clk);
        chk("post_rst_quiet", ev_cnt - base, 0);
        chk("post_rst_valid", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
